// File: rtl/reaction_score_gen_if.sv
// rtl/reaction_score_gen_if.sv - score producer handshake bundle
//
// Purpose: groups the trial control inputs and the score/status outputs of
// reaction_score_gen so they travel together to the consumer.
// Signals:
//   start        request to begin a trial (single cycle)
//   stop         player button press (single cycle)
//   led_on       reaction count running
//   busy         trial in progress (WAIT or TIMING)
//   score        BCD score, digit 0 in bits [3:0]
//   score_valid  one-cycle pulse when score is final
//   early        stop was pressed before the LED came on
//   timeout      trial ended by reaching the maximum score
// Modports: master = score producer, slave = consumer / stimulus side.

interface reaction_score_gen_if #(
   parameter int N = 4
);
   logic           start;
   logic           stop;
   logic           led_on;
   logic           busy;
   logic [4*N-1:0] score;
   logic           score_valid;
   logic           early;
   logic           timeout;

   modport master (
      input  start, stop,
      output led_on, busy, score, score_valid, early, timeout
   );

   modport slave (
      output start, stop,
      input  led_on, busy, score, score_valid, early, timeout
   );
endinterface

// File: rtl/reaction_score_gen.sv
// rtl/reaction_score_gen.sv - reaction timer trial FSM producing a BCD score
//
// Purpose: runs one reaction trial per start request: pseudo-random wait,
// LED on, BCD millisecond count until stop, then a frozen score with a
// one-cycle valid pulse. Lower score is better.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   sif    reaction_score_gen_if.master (start/stop in; led_on, busy, score,
//          score_valid, early, timeout out)
// Optional feature macro: SCORE_TIMEOUT_EN -- when defined, a TIMING trial
// that reaches all 9s ends on the next ms tick with timeout=1; when undefined
// the score saturates and timeout is tied 0.

module reaction_score_gen #(
   parameter int N            = 4,
   parameter int TICKS_PER_MS = 50000,
   parameter int DELAY_MIN_MS = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   reaction_score_gen_if.master sif
);

   localparam int SW = 4 * N;
   localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   // Wide enough for DELAY_MIN_MS + 1023.
   localparam int DW = $clog2(DELAY_MIN_MS + 1024);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      TIMING,
      DONE,
      EARLY
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      lfsr_q, lfsr_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [DW-1:0]   delay_q, delay_d;
   logic [SW-1:0]   score_q, score_d;
   logic            led_on_q, led_on_d;
   logic            busy_q, busy_d;
   logic            score_valid_q, score_valid_d;
   logic            early_q, early_d;
   logic            tick;
   logic            all_nines;
`ifdef SCORE_TIMEOUT_EN
   logic            timeout_q, timeout_d;
   logic            timeout_hit;
`endif

   // Ripple-carry BCD increment; wraps all 9s to 0 (caller guards saturation).
   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick      = (presc_q == PW'(TICKS_PER_MS - 1));
   assign all_nines = (score_q == {N{4'h9}});

   always_comb begin
      state_d  = state_q;
      // x^10 + x^7 + 1, taps at bits 9 and 6; free-runs in every state.
      lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      delay_d  = delay_q;
      score_d  = score_q;
`ifdef SCORE_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif

      case (state_q)
         IDLE, DONE, EARLY: begin
            // start has priority over a simultaneous stop here.
            if (sif.start) begin
               state_d = WAIT;
               delay_d = DW'(DELAY_MIN_MS) + DW'(lfsr_q);
            end
         end
         WAIT: begin
            // A stop coinciding with delay expiry is still an early press.
            if (sif.stop) begin
               state_d = EARLY;
            end else if (tick) begin
               if (delay_q <= DW'(1)) begin
                  state_d = TIMING;
                  delay_d = '0;
                  score_d = '0;
               end else begin
                  delay_d = delay_q - DW'(1);
               end
            end
         end
         TIMING: begin
            // A tick landing on the stop edge is not counted.
            if (sif.stop) begin
               state_d = DONE;
            end else if (tick) begin
               if (all_nines) begin
`ifdef SCORE_TIMEOUT_EN
                  state_d     = DONE;
                  timeout_hit = 1'b1;
`endif
               end else begin
                  score_d = bcd_inc(score_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Prescaler restarts on every state change so each phase measures
      // whole milliseconds from its own entry edge.
      if (state_d != state_q || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end

      led_on_d      = (state_d == TIMING);
      busy_d        = (state_d == WAIT) || (state_d == TIMING);
      early_d       = (state_d == EARLY);
      score_valid_d = (state_d == DONE) && (state_q != DONE);
`ifdef SCORE_TIMEOUT_EN
      timeout_d     = (state_d == DONE) && (timeout_hit || timeout_q);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         lfsr_q        <= 10'h001;
         presc_q       <= '0;
         delay_q       <= '0;
         score_q       <= '0;
         led_on_q      <= 1'b0;
         busy_q        <= 1'b0;
         score_valid_q <= 1'b0;
         early_q       <= 1'b0;
`ifdef SCORE_TIMEOUT_EN
         timeout_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         presc_q       <= presc_d;
         delay_q       <= delay_d;
         score_q       <= score_d;
         led_on_q      <= led_on_d;
         busy_q        <= busy_d;
         score_valid_q <= score_valid_d;
         early_q       <= early_d;
`ifdef SCORE_TIMEOUT_EN
         timeout_q     <= timeout_d;
`endif
      end
   end

   assign sif.led_on      = led_on_q;
   assign sif.busy        = busy_q;
   assign sif.score       = score_q;
   assign sif.score_valid = score_valid_q;
   assign sif.early       = early_q;
`ifdef SCORE_TIMEOUT_EN
   assign sif.timeout     = timeout_q;
`else
   assign sif.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_score_gen.sv
// tb/tb_reaction_score_gen.sv - directed-vector bench for reaction_score_gen
//
// Purpose: drives two instances (A: TICKS_PER_MS=2, B: TICKS_PER_MS=1, both
// DELAY_MIN_MS=3, N=4) and compares outputs against hand-computed values.
// Ports: none (top-level bench).

module tb_reaction_score_gen;

   logic clk;
   logic reset_a;
   logic reset_b;
   int   vec_cnt;
   int   miscmp_cnt;

   reaction_score_gen_if #(.N(4)) a_if ();
   reaction_score_gen_if #(.N(4)) b_if ();

   reaction_score_gen #(.N(4), .TICKS_PER_MS(2), .DELAY_MIN_MS(3)) u_dut_a (
      .clk   (clk),
      .reset (reset_a),
      .sif   (a_if.master)
   );

   reaction_score_gen #(.N(4), .TICKS_PER_MS(1), .DELAY_MIN_MS(3)) u_dut_b (
      .clk   (clk),
      .reset (reset_b),
      .sif   (b_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {led_on, busy, score_valid, early, timeout}
   function automatic logic [4:0] flags_a();
      return {a_if.led_on, a_if.busy, a_if.score_valid, a_if.early, a_if.timeout};
   endfunction

   function automatic logic [4:0] flags_b();
      return {b_if.led_on, b_if.busy, b_if.score_valid, b_if.early, b_if.timeout};
   endfunction

   task automatic wait_led_a(input string tag);
      int n;
      n = 0;
      while (a_if.led_on !== 1'b1 && n < 2200) begin
         @(negedge clk);
         n++;
      end
      expect_eq(tag, 32'(a_if.led_on), 32'd1);
   endtask

   initial begin
      vec_cnt    = 0;
      miscmp_cnt = 0;
      reset_a    = 1'b1;
      reset_b    = 1'b1;
      a_if.start = 1'b0;
      a_if.stop  = 1'b0;
      b_if.start = 1'b0;
      b_if.stop  = 1'b0;

      repeat (2) @(negedge clk);
      expect_eq("a_rst_flags", 32'(flags_a()), 32'h00);
      expect_eq("a_rst_score", 32'(a_if.score), 32'h0000);

      // First trial: LFSR=1 at the start edge gives a 4 ms (8 cycle) delay.
      reset_a    = 1'b0;
      a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      expect_eq("a_start_flags", 32'(flags_a()), 32'h08);
      repeat (7) @(negedge clk);
      expect_eq("a_led_pre", 32'(a_if.led_on), 32'd0);
      @(negedge clk);
      expect_eq("a_led_rise", 32'(a_if.led_on), 32'd1);
      expect_eq("a_score_clr", 32'(a_if.score), 32'h0000);
      repeat (10) @(negedge clk);
      expect_eq("a_score_5", 32'(a_if.score), 32'h0005);
      a_if.stop = 1'b1;
      @(negedge clk);
      a_if.stop = 1'b0;
      expect_eq("a_done_flags", 32'(flags_a()), 32'h04);
      expect_eq("a_done_score", 32'(a_if.score), 32'h0005);
      @(negedge clk);
      expect_eq("a_valid_drop", 32'(flags_a()), 32'h00);
      expect_eq("a_score_hold", 32'(a_if.score), 32'h0005);

      // Early stop during WAIT.
      a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      expect_eq("a_wait_flags", 32'(flags_a()), 32'h08);
      a_if.stop = 1'b1;
      @(negedge clk);
      a_if.stop = 1'b0;
      expect_eq("a_early_flags", 32'(flags_a()), 32'h02);
      expect_eq("a_early_score", 32'(a_if.score), 32'h0005);
      a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      expect_eq("a_restart_flags", 32'(flags_a()), 32'h08);

      // BCD 9 -> 10 with an ignored start in the middle of TIMING.
      wait_led_a("a_led_wait1");
      repeat (5) @(negedge clk);
      a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      repeat (12) @(negedge clk);
      expect_eq("a_score_9", 32'(a_if.score), 32'h0009);
      expect_eq("a_timing_flags", 32'(flags_a()), 32'h18);
      repeat (2) @(negedge clk);
      expect_eq("a_score_10", 32'(a_if.score), 32'h0010);
      a_if.stop = 1'b1;
      @(negedge clk);
      a_if.stop = 1'b0;
      expect_eq("a_done10_flags", 32'(flags_a()), 32'h04);
      expect_eq("a_done10_score", 32'(a_if.score), 32'h0010);

      // start and stop together in DONE: start wins.
      a_if.start = 1'b1;
      a_if.stop  = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      a_if.stop  = 1'b0;
      expect_eq("a_startstop_flags", 32'(flags_a()), 32'h08);

      // Asynchronous reset in the middle of TIMING.
      wait_led_a("a_led_wait2");
      repeat (3) @(negedge clk);
      expect_eq("a_score_1", 32'(a_if.score), 32'h0001);
      #2 reset_a = 1'b1;
      #1;
      expect_eq("a_arst_flags", 32'(flags_a()), 32'h00);
      expect_eq("a_arst_score", 32'(a_if.score), 32'h0000);
      @(negedge clk);
      expect_eq("a_arst_hold", 32'(flags_a()), 32'h00);

      // Instance B: five LFSR updates (1->2->4->8->16->32) then start: delay 35.
      reset_b = 1'b0;
      repeat (5) @(negedge clk);
      b_if.start = 1'b1;
      @(negedge clk);
      b_if.start = 1'b0;
      repeat (34) @(negedge clk);
      expect_eq("b_led_pre", 32'(flags_b()), 32'h08);
      @(negedge clk);
      expect_eq("b_led_rise", 32'(flags_b()), 32'h18);
      repeat (999) @(negedge clk);
      expect_eq("b_score_999", 32'(b_if.score), 32'h0999);
      @(negedge clk);
      expect_eq("b_score_1000", 32'(b_if.score), 32'h1000);
      repeat (8999) @(negedge clk);
      expect_eq("b_score_9999", 32'(b_if.score), 32'h9999);
      expect_eq("b_sat_flags", 32'(flags_b()), 32'h18);
      @(negedge clk);
`ifdef SCORE_TIMEOUT_EN
      expect_eq("b_to_flags", 32'(flags_b()), 32'h05);
      expect_eq("b_to_score", 32'(b_if.score), 32'h9999);
      @(negedge clk);
      expect_eq("b_to_hold", 32'(flags_b()), 32'h01);
      b_if.start = 1'b1;
      @(negedge clk);
      b_if.start = 1'b0;
      expect_eq("b_to_leave", 32'(flags_b()), 32'h08);
`else
      expect_eq("b_sat_score", 32'(b_if.score), 32'h9999);
      expect_eq("b_sat_flags2", 32'(flags_b()), 32'h18);
      repeat (5) @(negedge clk);
      expect_eq("b_sat_hold", 32'(b_if.score), 32'h9999);
      b_if.stop = 1'b1;
      @(negedge clk);
      b_if.stop = 1'b0;
      expect_eq("b_sat_done", 32'(flags_b()), 32'h04);
      expect_eq("b_sat_done_score", 32'(b_if.score), 32'h9999);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
